// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers and read-mode encoding for the synchronous FIFO family.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } rd_mode_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the count can represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// fifo_sdp_ram: WIDTH x DEPTH simple dual-port storage, synchronous write, asynchronous read.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [addr_w(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [addr_w(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: parametrised single-clock FIFO with standard or first-word-fall-through reads.
// Sticky overflow/underflow flags are built only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  output logic                   full_o,
  output logic                   almost_full_o,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   rd_valid_o,
  output logic                   empty_o,
  output logic                   almost_empty_o,
  output logic [addr_w(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int AW = addr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);
  localparam rd_mode_e      MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] ram_rdata;
  logic             wa, ra;

  assign empty_o        = count_q == '0;
  assign full_o         = count_q == FULL_CNT;
  assign almost_full_o  = count_q >= AF_CNT;
  assign almost_empty_o = count_q <= AE_CNT;
  assign count_o        = count_q;

  // Acceptance is judged on the registered state only, so a full FIFO never passes a word through.
  assign wa = wr_en_i && !full_o;
  assign ra = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wa);
    rd_ptr_d = rd_ptr_q + AW'(ra);
    count_d  = count_q + CW'(wa) - CW'(ra);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_sdp_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wa),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign rd_data_o  = ram_rdata;
    assign rd_valid_o = !empty_o;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    always_comb begin
      rd_data_d  = ra ? ram_rdata : rd_data_q;
      rd_valid_d = ra;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= rd_valid_d;
      end
    end
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (wr_en_i & full_o);
    underflow_d = underflow_q | (rd_en_i & empty_o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule
